accum_cpu_core: RTL

Synthesisable multicycle accumulator CPU core. It replaces the behavioural fetch/decode/execute loop with a parametrised FSM that drives a single-port synchronous RAM (1-cycle registered read). The ISA is fixed, including signed skip conditions. It adds a start/halted handshake and a retired-instruction counter.

---
 rtl/accum_cpu_pkg.sv | 39 +++
 rtl/accum_alu.sv | 28 ++
 rtl/accum_cpu_core.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/accum_cpu_pkg.sv
// accum_cpu_pkg: shared ISA and FSM definitions for the accumulator CPU core.
// Opcode field values, SKIPCOND condition codes and the controller state encoding.
package accum_cpu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LOAD     = 4'h0;
  localparam logic [OPC_W-1:0] OP_STORE    = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD      = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB      = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND      = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR       = 4'h5;
  localparam logic [OPC_W-1:0] OP_SKIPCOND = 4'h6;
  localparam logic [OPC_W-1:0] OP_JUMP     = 4'h7;
  localparam logic [OPC_W-1:0] OP_CLEAR    = 4'h8;
  localparam logic [OPC_W-1:0] OP_HALT     = 4'h9;

  // SKIPCOND condition codes, taken from the two top bits of the operand field
  localparam logic [1:0] COND_NEG   = 2'b00;
  localparam logic [1:0] COND_ZERO  = 2'b01;
  localparam logic [1:0] COND_POS   = 2'b10;
  localparam logic [1:0] COND_NEVER = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LATCH    = 3'd2,
    EXEC     = 3'd3,
    MEM_WAIT = 3'd4,
    ALU      = 3'd5,
    HALTED   = 3'd6
  } state_t;

  // Opcodes A-F have no defined behaviour
  function automatic logic is_defined_op(input logic [OPC_W-1:0] op);
    return (op <= OP_HALT);
  endfunction

endpackage

// File: rtl/accum_alu.sv
// accum_alu: combinational accumulator update for the memory-operand instructions.
// LOAD passes the memory word through; ADD/SUB wrap with no flags.
module accum_alu
  import accum_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [OPC_W-1:0]      i_opcode,
  input  logic [DATA_WIDTH-1:0] i_ac,
  input  logic [DATA_WIDTH-1:0] i_mbr,
  output logic [DATA_WIDTH-1:0] o_result
);

  // Select the new accumulator value from the opcode
  always_comb begin
    // NOTE: assign a default before the case so every path drives o_result and no latch is inferred.
    o_result = i_ac;
    case (i_opcode)
      OP_LOAD: o_result = i_mbr;
      OP_ADD:  o_result = i_ac + i_mbr;
      OP_SUB:  o_result = i_ac - i_mbr;
      OP_AND:  o_result = i_ac & i_mbr;
      OP_OR:   o_result = i_ac | i_mbr;
      default: o_result = i_ac;
    endcase
  end

endmodule

// File: rtl/accum_cpu_core.sv
// accum_cpu_core: multicycle accumulator CPU driving a single-port synchronous RAM
// with a one-cycle registered read. Start/halted handshake, retired-instruction counter
// and a sticky illegal-opcode flag.
// Build option: define ACCUM_TRAP_ILLEGAL_EN to halt on an undefined opcode instead of
// treating it as a NOP.
module accum_cpu_core
  import accum_cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  halted,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [CNT_WIDTH-1:0]  retired,
  output logic                  illegal
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [DATA_WIDTH-1:0]   r_ac;
  logic [DATA_WIDTH-1:0]   r_ir;
  logic [DATA_WIDTH-1:0]   r_mbr;
  logic [CNT_WIDTH-1:0]    r_retired;
  logic                    r_illegal;

  logic [OPC_W-1:0]        w_opcode;
  logic [ADDR_WIDTH-1:0]   w_operand;
  logic [1:0]              w_cond;
  logic                    w_skip;
  logic                    w_retire;
  logic [DATA_WIDTH-1:0]   w_alu_result;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic                    w_mem_cs;
  logic                    w_mem_we;
  logic                    w_mem_oe;

  assign w_opcode  = r_ir[DATA_WIDTH-1 -: OPC_W];
  assign w_operand = r_ir[ADDR_WIDTH-1:0];
  assign w_cond    = r_ir[ADDR_WIDTH-1 -: 2];

  // IR bits between the operand and the opcode carry no meaning
  if (DATA_WIDTH > ADDR_WIDTH + OPC_W) begin : g_ir_gap
    logic w_unused_ir_gap;
    assign w_unused_ir_gap = ^r_ir[DATA_WIDTH-OPC_W-1:ADDR_WIDTH];
  end

  accum_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_opcode (w_opcode),
    .i_ac     (r_ac),
    .i_mbr    (r_mbr),
    .o_result (w_alu_result)
  );

  // Evaluate the signed SKIPCOND test against the current accumulator
  always_comb begin
    w_skip = 1'b0;
    case (w_cond)
      COND_NEG:  w_skip = r_ac[DATA_WIDTH-1];
      COND_ZERO: w_skip = (r_ac == '0);
      COND_POS:  w_skip = !r_ac[DATA_WIDTH-1] && (r_ac != '0);
      default:   w_skip = 1'b0;
    endcase
  end

  // Next-state, memory strobes and retire pulse for the controller
  always_comb begin
    w_next_state = r_state;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_mem_cs     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_oe     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      IDLE, HALTED: begin
        if (start) w_next_state = FETCH;
      end
      FETCH: begin
        w_mem_addr   = r_pc;
        w_mem_cs     = 1'b1;
        w_mem_oe     = 1'b1;
        w_next_state = LATCH;
      end
      LATCH: w_next_state = EXEC;
      EXEC: begin
        case (w_opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_mem_addr   = w_operand;
            w_mem_cs     = 1'b1;
            w_mem_oe     = 1'b1;
            w_next_state = MEM_WAIT;
          end
          OP_STORE: begin
            w_mem_addr   = w_operand;
            w_mem_wdata  = r_ac;
            w_mem_cs     = 1'b1;
            w_mem_we     = 1'b1;
            w_next_state = FETCH;
            w_retire     = 1'b1;
          end
          OP_SKIPCOND, OP_JUMP, OP_CLEAR: begin
            w_next_state = FETCH;
            w_retire     = 1'b1;
          end
          OP_HALT: begin
            w_next_state = HALTED;
            w_retire     = 1'b1;
          end
          default: begin
`ifdef ACCUM_TRAP_ILLEGAL_EN
            // Trap: stop without counting the offending word as retired
            w_next_state = HALTED;
`else
            w_next_state = FETCH;
            w_retire     = 1'b1;
`endif
          end
        endcase
      end
      MEM_WAIT: w_next_state = ALU;
      ALU: begin
        w_next_state = FETCH;
        w_retire     = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Datapath registers: PC, IR, MBR, accumulator, retire counter and illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_ac      <= '0;
      r_ir      <= '0;
      r_mbr     <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_retire) r_retired <= r_retired + CNT_WIDTH'(1);
      case (r_state)
        IDLE, HALTED: begin
          if (start) r_pc <= RESET_PC;
        end
        LATCH: begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + ADDR_WIDTH'(1);
        end
        EXEC: begin
          case (w_opcode)
            OP_SKIPCOND: if (w_skip) r_pc <= r_pc + ADDR_WIDTH'(1);
            OP_JUMP:     r_pc <= w_operand;
            OP_CLEAR:    r_ac <= '0;
            default:     if (!is_defined_op(w_opcode)) r_illegal <= 1'b1;
          endcase
        end
        MEM_WAIT: r_mbr <= mem_rdata;
        ALU:      r_ac  <= w_alu_result;
        default: ;
      endcase
    end
  end

  // Strobes are forced low while rst is high so a write in flight at reset never lands
  assign mem_addr  = rst ? '0 : w_mem_addr;
  assign mem_wdata = rst ? '0 : w_mem_wdata;
  assign mem_cs    = w_mem_cs & ~rst;
  assign mem_we    = w_mem_we & ~rst;
  assign mem_oe    = w_mem_oe & ~rst;

  assign halted  = (r_state == HALTED);
  assign busy    = (r_state != IDLE) && (r_state != HALTED);
  assign acc     = r_ac;
  assign pc      = r_pc;
  assign retired = r_retired;
  assign illegal = r_illegal;

endmodule
